// File: rtl/sdcard_pkg.sv
// sdcard_pkg: shared constants and types for the SD card SPI target
package sdcard_pkg;
  localparam logic [7:0] SD_IDLE_BYTE = 8'hFF;
  localparam int CNT_W = 3;
  typedef enum logic {SPI_IDLE, SPI_ACTIVE} spi_state_e;
endpackage

// File: rtl/sdcard_sync.sv
// sdcard_sync: STAGES-deep single-bit synchroniser (clk, rst async high, d in, q out) with reset value RST_VAL
module sdcard_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] s_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) s_q <= {STAGES{RST_VAL}};
    else     s_q <= {s_q[STAGES-2:0], d};
  assign q = s_q[STAGES-1];
endmodule

// File: rtl/sdcard_spi_target.sv
// sdcard_spi_target: SPI mode-0 card-side target; oversamples sclk/mosi/cs_n in clk, drives miso/miso_oe,
// one-entry TX holding register (tx_data/tx_valid/tx_ready), RX byte strobe (rx_data/rx_valid),
// status (selected/underrun) and per-bit CRC taps (crc_in_bit/crc_out_bit/crc_strobe).
module sdcard_spi_target
  import sdcard_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = SD_IDLE_BYTE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       cs_n,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       selected,
  output logic       underrun,
  output logic       crc_in_bit,
  output logic       crc_out_bit,
  output logic       crc_strobe
);
  logic sclk_s, mosi_s, cs_s, sclk_q, cs_q;
  sdcard_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (.clk(clk), .rst(rst), .d(sclk), .q(sclk_s));
  sdcard_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_mosi (.clk(clk), .rst(rst), .d(mosi), .q(mosi_s));
  sdcard_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs   (.clk(clk), .rst(rst), .d(cs_n), .q(cs_s));
  wire sclk_rise = sclk_s & ~sclk_q;
  wire sclk_fall = ~sclk_s & sclk_q;
  wire cs_fall   = ~cs_s & cs_q;
  wire cs_rise   = cs_s & ~cs_q;
  spi_state_e       state_q, state_d;
  logic [7:0]       shifter_q, shifter_d, shift_in_q, shift_in_d, rx_data_q, rx_data_d, hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, full_d, rx_valid_q, rx_valid_d, underrun_q, underrun_d;
  logic             crc_strobe_q, crc_strobe_d, crc_in_q, crc_in_d, crc_out_q, crc_out_d;
  logic             load, capture;
  always_comb begin
    state_d      = state_q;
    shifter_d    = shifter_q;
    shift_in_d   = shift_in_q;
    cnt_d        = cnt_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    underrun_d   = 1'b0;
    crc_strobe_d = 1'b0;
    crc_in_d     = crc_in_q;
    crc_out_d    = crc_out_q;
    load         = 1'b0;
    capture      = tx_valid & ~full_q;
    hold_d       = capture ? tx_data : hold_q;
    if (state_q == SPI_IDLE) begin
      if (cs_fall) begin
        state_d = SPI_ACTIVE;
        load    = 1'b1;
        cnt_d   = '0;
      end
    end else if (cs_rise) begin
      state_d = SPI_IDLE;
      cnt_d   = '0;
    end else begin
      if (sclk_rise) begin
        shift_in_d   = {shift_in_q[6:0], mosi_s};
        cnt_d        = cnt_q + 1'b1;
        crc_strobe_d = 1'b1;
        crc_in_d     = mosi_s;
        crc_out_d    = shifter_q[7];
        rx_data_d    = (cnt_q == '1) ? shift_in_d : rx_data_q;
        rx_valid_d   = (cnt_q == '1);
      end
      if (sclk_fall) begin
        load      = (cnt_q == '0);
        shifter_d = {shifter_q[6:0], 1'b1};
      end
    end
    // Consume sees the pre-capture state, so a same-cycle write waits for the next boundary.
    if (load) begin
      shifter_d  = full_q ? hold_q : IDLE_BYTE;
      underrun_d = ~full_q;
    end
    full_d = (full_q & ~load) | capture;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sclk_q       <= 1'b0;
      cs_q         <= 1'b1;
      state_q      <= SPI_IDLE;
      shifter_q    <= IDLE_BYTE;
      shift_in_q   <= '0;
      cnt_q        <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      underrun_q   <= 1'b0;
      crc_strobe_q <= 1'b0;
      crc_in_q     <= 1'b0;
      crc_out_q    <= 1'b0;
      hold_q       <= '0;
      full_q       <= 1'b0;
    end else begin
      sclk_q       <= sclk_s;
      cs_q         <= cs_s;
      state_q      <= state_d;
      shifter_q    <= shifter_d;
      shift_in_q   <= shift_in_d;
      cnt_q        <= cnt_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      underrun_q   <= underrun_d;
      crc_strobe_q <= crc_strobe_d;
      crc_in_q     <= crc_in_d;
      crc_out_q    <= crc_out_d;
      hold_q       <= hold_d;
      full_q       <= full_d;
    end
  assign selected    = (state_q == SPI_ACTIVE);
  assign miso_oe     = selected;
  assign miso        = selected ? shifter_q[7] : 1'b1;
  assign tx_ready    = ~full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign underrun    = underrun_q;
  assign crc_strobe  = crc_strobe_q;
  assign crc_in_bit  = crc_in_q;
  assign crc_out_bit = crc_out_q;
endmodule

// File: tb/tb_sdcard_spi_target.sv
// tb_sdcard_spi_target: directed bench with a transaction-level card model and a per-cycle output checker
module tb_sdcard_spi_target;
  logic clk = 0, rst = 1, sclk = 0, mosi = 1, cs_n = 1, tx_valid = 0;
  logic [7:0] tx_data = 0;
  logic miso, miso_oe, tx_ready, rx_valid, selected, underrun, crc_in_bit, crc_out_bit, crc_strobe;
  logic [7:0] rx_data;
  sdcard_spi_target #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .selected(selected), .underrun(underrun), .crc_in_bit(crc_in_bit), .crc_out_bit(crc_out_bit),
    .crc_strobe(crc_strobe)
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0, hp = 6;
  int rx_cnt = 0, ur_cnt = 0, st_cnt = 0, ur_exp = 0;
  logic [7:0] tx_q[$], exp_rx[$];
  logic crc_in_q[$], crc_out_q[$];
  logic [7:0] last_rx = 0, cur_exp = 8'hFF, in_log = 0, out_log = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s", name);
  endtask
  // Card model: every byte load takes the held byte if any, otherwise the idle byte with an underrun.
  task automatic model_load();
    if (tx_q.size() != 0) cur_exp = tx_q.pop_front();
    else begin
      cur_exp = 8'hFF;
      ur_exp++;
    end
  endtask
  task automatic select();
    cs_n = 0;
    repeat (6) @(negedge clk);
    model_load();
  endtask
  task automatic deselect();
    cs_n = 1;
    sclk = 0;
    repeat (6) @(negedge clk);
  endtask
  task automatic write(input logic [7:0] d);
    int n = 0;
    while (!tx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) fail("tx_ready_timeout");
    else begin
      tx_data  = d;
      tx_valid = 1;
      @(negedge clk);
      tx_valid = 0;
      tx_q.push_back(d);
    end
  endtask
  task automatic xfer(input logic [7:0] mo, input int n, output logic [7:0] mi);
    logic [7:0] e = cur_exp;
    logic b;
    mi = 0;
    for (int i = 0; i < n; i++) begin
      mosi = mo[7-i];
      repeat (hp) @(negedge clk);
      b  = miso;
      mi = {mi[6:0], b};
      crc_in_q.push_back(mosi);
      crc_out_q.push_back(b);
      if (n == 8 && i == 7) exp_rx.push_back(mo);
      sclk = 1;
      repeat (hp) @(negedge clk);
      sclk = 0;
    end
    repeat (hp) @(negedge clk);
    if (n == 8) begin
      chk("miso_byte", mi, e);
      model_load();
    end
  endtask
  always @(negedge clk)
    if (rst) last_rx = 0;
    else begin
      if (rx_valid) begin
        if (exp_rx.size() == 0) fail("rx_valid_unexpected");
        else chk("rx_data", rx_data, exp_rx.pop_front());
        last_rx = rx_data;
        rx_cnt++;
      end else chk("rx_hold", rx_data, last_rx);
      if (underrun) ur_cnt++;
      if (crc_strobe) begin
        st_cnt++;
        in_log  = {in_log[6:0], crc_in_bit};
        out_log = {out_log[6:0], crc_out_bit};
        if (crc_in_q.size() == 0) fail("crc_strobe_unexpected");
        else begin
          chk("crc_in", crc_in_bit, crc_in_q.pop_front());
          chk("crc_out", crc_out_bit, crc_out_q.pop_front());
        end
      end
    end
  initial begin
    #5_000_000;
    $display("FAIL watchdog");
    $fatal(1, "timeout");
  end
  initial begin
    logic [7:0] mi;
    int rc0, sc0, u0;
    repeat (3) @(negedge clk);
    chk("rst_miso", miso, 1);
    chk("rst_oe", miso_oe, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_strobe", crc_strobe, 0);
    chk("rst_selected", selected, 0);
    rst = 0;
    @(negedge clk);
    write(8'hA5);
    chk("tx_ready_full", tx_ready, 0);
    select();
    chk("selected", selected, 1);
    chk("oe_on", miso_oe, 1);
    chk("tx_ready_consumed", tx_ready, 1);
    xfer(8'h3C, 8, mi);
    chk("rd_A5", mi, 8'hA5);
    deselect();
    chk("oe_off", miso_oe, 0);
    chk("miso_idle", miso, 1);
    chk("deselected", selected, 0);
    chk("rx_3C", rx_data, 8'h3C);
    chk("rx_cnt1", rx_cnt, 1);
    chk("ur_a", ur_cnt, ur_exp);
    write(8'h01);
    select();
    write(8'h02);
    xfer(8'h40, 8, mi);
    chk("rd_01", mi, 8'h01);
    xfer(8'h00, 8, mi);
    chk("rd_02", mi, 8'h02);
    deselect();
    chk("rx_00", rx_data, 8'h00);
    chk("rx_cnt3", rx_cnt, 3);
    chk("rx_pending", exp_rx.size(), 0);
    u0 = ur_cnt;
    select();
    xfer(8'h55, 8, mi);
    chk("rd_FF", mi, 8'hFF);
    deselect();
    chk("ur_two", ur_cnt - u0, 2);
    chk("ur_b", ur_cnt, ur_exp);
    rc0 = rx_cnt;
    select();
    write(8'h5A);
    xfer(8'hFF, 5, mi);
    deselect();
    chk("abort_no_rx", rx_cnt, rc0);
    chk("abort_rx_kept", rx_data, 8'h55);
    chk("abort_hold_kept", tx_ready, 0);
    select();
    xfer(8'hC3, 8, mi);
    chk("rd_5A", mi, 8'h5A);
    deselect();
    chk("rx_C3", rx_data, 8'hC3);
    hp = 4;
    write(8'h96);
    sc0 = st_cnt;
    select();
    xfer(8'h40, 8, mi);
    deselect();
    hp = 6;
    chk("rd_96", mi, 8'h96);
    chk("crc_strobes", st_cnt - sc0, 8);
    chk("crc_in_seq", in_log, 8'h40);
    chk("crc_out_seq", out_log, 8'h96);
    select();
    xfer(8'hAA, 4, mi);
    rc0 = rx_cnt;
    rst = 1;
    #1;
    chk("mid_rst_miso", miso, 1);
    chk("mid_rst_oe", miso_oe, 0);
    chk("mid_rst_tx_ready", tx_ready, 1);
    chk("mid_rst_rx_valid", rx_valid, 0);
    cs_n = 1;
    sclk = 0;
    tx_q.delete();
    exp_rx.delete();
    crc_in_q.delete();
    crc_out_q.delete();
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    chk("mid_rst_no_rx", rx_cnt, rc0);
    chk("mid_rst_rx_data", rx_data, 0);
    select();
    xfer(8'h81, 8, mi);
    chk("rd_after_rst", mi, 8'hFF);
    deselect();
    chk("rx_81", rx_data, 8'h81);
    chk("ur_c", ur_cnt, ur_exp);
    chk("crc_pending", crc_in_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
